// File: rtl/mem_port_ctrl.sv
// Memory port controller for a multicycle core: latches a read/write command,
// runs a request/ack handshake with a timeout, and stalls the controller meanwhile.
module mem_port_ctrl #(
  parameter int AW      = 12,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic          IRwrite,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] inst,
  output logic [DW-1:0] mdr,
  output logic          busy,
  output logic          err
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic          irsel_q, irsel_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [DW-1:0] inst_q, inst_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic          err_q, err_d;

  logic cmd_ok, conflict;
  assign conflict = MemRead & MemWrite;
  assign cmd_ok   = MemRead ^ MemWrite;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    irsel_d = irsel_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    inst_d  = inst_q;
    mdr_d   = mdr_q;
    err_d   = err_q;
    busy    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (conflict) begin
          err_d = 1'b1;
        end else if (cmd_ok) begin
          busy    = 1'b1;
          adr_d   = adr;
          wd_d    = wdata;
          we_d    = MemWrite;
          irsel_d = MemRead & IRwrite;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        busy = 1'b1;
        // ack takes priority over the timeout in the same cycle
        if (mem_ack) begin
          if (!we_q) begin
            mdr_d = mem_rdata;
            if (irsel_q) inst_d = mem_rdata;
          end
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == TMAX) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      irsel_q <= 1'b0;
      adr_q   <= '0;
      wd_q    <= '0;
      inst_q  <= '0;
      mdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      irsel_q <= irsel_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      inst_q  <= inst_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_adr   = adr_q;
  assign mem_wdata = wd_q;
  assign inst      = inst_q;
  assign mdr       = mdr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: stimulus tasks set per-cycle expectations from
// the access rules; one negedge process compares every output against them.
module tb_mem_port_ctrl;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          rst;
  logic          MemRead, MemWrite, IRwrite, mem_ack;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdata, mem_rdata;
  logic          mem_req, mem_we, busy, err;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata, inst, mdr;

  mem_port_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRwrite(IRwrite), .adr(adr), .wdata(wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .inst(inst), .mdr(mdr),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  // expected outputs for the current cycle
  logic          e_busy, e_req, e_we, e_err;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_wd, e_inst, e_mdr;
  int n_chk = 0, n_err = 0;
  int busy_cnt = 0, req_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("busy", 32'(busy), 32'(e_busy));
    chk("mem_req", 32'(mem_req), 32'(e_req));
    if (e_req) chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_adr", 32'(mem_adr), 32'(e_adr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    chk("inst", 32'(inst), 32'(e_inst));
    chk("mdr", 32'(mdr), 32'(e_mdr));
    chk("err", 32'(err), 32'(e_err));
    if (busy) busy_cnt++;
    if (mem_req) req_cnt++;
  end

  task automatic idle_inputs();
    MemRead = 0; MemWrite = 0; IRwrite = 0; mem_ack = 0;
    adr = '0; wdata = '0; mem_rdata = '0;
    e_busy = 0; e_req = 0;
  endtask

  task automatic clr_model();
    e_we = 0; e_err = 0; e_adr = '0; e_wd = '0; e_inst = '0; e_mdr = '0;
  endtask

  // Called #1 after a rising edge with the DUT idle; ack_cyc = REQ cycle of ack, 0 = never.
  task automatic access(input logic rd, input logic wr, input logic irw,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int ack_cyc, input logic [DW-1:0] rdat);
    MemRead = rd; MemWrite = wr; IRwrite = irw; adr = a; wdata = wd; mem_ack = 0;
    e_req = 0; e_busy = rd ^ wr;
    @(posedge clock); #1;
    if (rd & wr) begin e_err = 1; idle_inputs(); return; end
    if (!(rd | wr)) begin idle_inputs(); return; end
    e_adr = a; e_wd = wd; e_we = wr;
    // scrambled command inputs during REQ must not matter
    MemRead = ~rd; MemWrite = rd; IRwrite = ~irw; adr = ~a; wdata = ~wd; mem_rdata = rdat;
    for (int k = 1; k <= TO + 1; k++) begin
      e_req = 1; e_busy = 1; mem_ack = (k == ack_cyc);
      @(posedge clock); #1;
      if (k == ack_cyc) begin
        if (rd) begin e_mdr = rdat; if (irw) e_inst = rdat; end
        break;
      end
      if (k == TO + 1) e_err = 1;
    end
    // DONE: a fresh command and a stray ack are both ignored
    e_req = 0; e_busy = 0;
    MemRead = 1; MemWrite = 0; IRwrite = 1; mem_ack = 1; mem_rdata = 16'hDEAD;
    @(posedge clock); #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 0; idle_inputs(); clr_model();
    repeat (2) @(posedge clock);
    #1 rst = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1);
  end

  initial begin
    do_reset();

    // fetch: ack on 3rd REQ cycle
    busy_cnt = 0;
    access(1, 0, 1, 12'h004, 16'h0000, 3, 16'h8123);
    chk("fetch_busy_cycles", busy_cnt, 4);
    chk("fetch_inst_lit", 32'(inst), 32'h8123);
    chk("fetch_mdr_lit", 32'(mdr), 32'h8123);

    // store with IRwrite set: no register update
    access(0, 1, 1, 12'h0A0, 16'hBEEF, 1, 16'h1111);
    chk("store_inst_lit", 32'(inst), 32'h8123);

    // back-to-back load then fetch
    access(1, 0, 0, 12'h123, 16'h0, 1, 16'h4242);
    chk("load_mdr_lit", 32'(mdr), 32'h4242);
    access(1, 0, 1, 12'h008, 16'h0, 2, 16'h7001);

    // IRwrite without MemRead: nothing happens
    access(0, 0, 1, 12'h555, 16'h0, 0, 16'h0);

    // ack in the final allowed cycle beats the timeout
    access(1, 0, 0, 12'hFFF, 16'h0, TO + 1, 16'hA5A5);
    chk("late_ack_no_err", 32'(err), 32'h0);

    // timeout
    req_cnt = 0;
    access(1, 0, 1, 12'h010, 16'h0, 0, 16'h9999);
    chk("timeout_req_cycles", req_cnt, TO + 1);
    chk("timeout_err_lit", 32'(err), 32'h1);
    chk("timeout_inst_kept", 32'(inst), 32'h7001);
    access(0, 1, 0, 12'h020, 16'h1234, 1, 16'h0);
    chk("err_sticky", 32'(err), 32'h1);

    // reset aborts a fetch in its 2nd REQ cycle
    do_reset();
    MemRead = 1; IRwrite = 1; adr = 12'h004; e_busy = 1;
    @(posedge clock); #1;
    idle_inputs(); e_adr = 12'h004; e_req = 1; e_busy = 1; e_we = 0;
    @(posedge clock); #1;
    rst = 0; idle_inputs(); clr_model();
    #1 chk("abort_req_async", 32'(mem_req), 32'h0);
    @(posedge clock); #1;
    rst = 1; mem_ack = 1; mem_rdata = 16'h5555;
    @(posedge clock); #1;
    mem_ack = 0;
    chk("abort_inst_zero", 32'(inst), 32'h0);
    access(1, 0, 1, 12'h00C, 16'h0, 1, 16'h0C0C);

    // conflicting command
    req_cnt = 0;
    access(1, 1, 0, 12'h0AA, 16'h0, 0, 16'h0);
    @(posedge clock); #1;
    chk("conflict_no_req", req_cnt, 0);
    chk("conflict_err_lit", 32'(err), 32'h1);

    @(posedge clock); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
